bus_trace: RTL and testbench
============================

BUS_TRACE -- requirements
Module: bus_trace

Interface
REQ-001 Parameter ADDR_W, 16, bus address width.
REQ-002 Parameter DATA_W, 8, bus data width.
REQ-003 Parameter DEPTH, 16, trace FIFO entries; power of two, minimum 2.
REQ-004 Parameter TS_W, 16, timestamp width.
REQ-005 Parameter MODE, 0, capture mode: 0 = all cycles, 1 = writes only, 2 = reads only.
REQ-006 Parameter WIN_LO, 0, lowest captured address, inclusive.
REQ-007 Parameter WIN_HI, all-ones, highest captured address, inclusive.
REQ-008 clk  in  1  single system clock; all logic on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 addr  in  ADDR_W  CPU address bus.
REQ-011 idata  in  DATA_W  data into CPU (read data).
REQ-012 odata  in  DATA_W  data out of CPU (write data).
REQ-013 rw  in  1  1 = read, 0 = write.
REQ-014 clk2  in  1  CPU phi2 phase, sampled by clk.
REQ-015 freeze  in  1  high inhibits capture; the FIFO stays readable.
REQ-016 rd_en  in  1  pop request.
REQ-017 rd_valid  out  1  one-cycle pulse marking valid rd_* fields.
REQ-018 rd_ts / rd_rw / rd_addr / rd_data  out  TS_W / 1 / ADDR_W / DATA_W  popped record fields.
REQ-019 count  out  log2(DEPTH)+1  current occupancy.
REQ-020 empty, full  out  1  occupancy flags.
REQ-021 overflow  out  1  sticky flag: a record was dropped.
REQ-022 drops  out  8  count of dropped records; saturates at 255.

Function
REQ-023 clk2 is registered to clk2_q each cycle.
- Phi2 rise = clk2 & !clk2_q.
- Phi2 fall = !clk2 & clk2_q.
REQ-024 Write capture: on a phi2 rise with rw=0, the candidate record is {ts, 0, addr, odata}.
REQ-025 Read capture: on a phi2 fall with rw=1, the candidate record is {ts, 1, addr, idata}.
REQ-026 A candidate is pushed only when all of the following hold:
- freeze=0;
- WIN_LO <= addr <= WIN_HI;
- MODE permits the cycle type.
REQ-027 The timestamp counter ts increments every clk and wraps to 0 after 2^TS_W-1; a record carries ts as of its capture cycle.
REQ-028 The FIFO is a circular buffer with wrapping read and write pointers; records are popped in push order.
REQ-029 Pop: rd_en=1 and empty=0 in cycle N -> rd_valid=1 with the record in cycle N+1.
- rd_en with empty=1 is ignored; rd_valid=0.
REQ-030 rd_* fields hold their last popped value while rd_valid=0.
REQ-031 Push with full=0: the record is stored and count increments.
REQ-032 Push with full=1 and no pop in the same cycle: the record is dropped, overflow is set, drops increments (saturating).
REQ-033 Push and pop in the same cycle: both succeed and count is unchanged, including when full=1.
REQ-034 full = (count == DEPTH); empty = (count == 0); both flags are combinational from count.
REQ-035 Asserting freeze mid-stream drops nothing and pops continue.
- A candidate in the same cycle that freeze rises is not captured.

Reset
REQ-036 Reset asserted clears the following asynchronously:
- pointers, count, ts, clk2_q, overflow, drops, rd_valid;
- all rd_* fields, to 0.
REQ-037 After reset, empty=1 and full=0.
REQ-038 Reset mid-stream discards all stored records; the first capture after release carries ts counted from release.

Configuration
REQ-039 Macro BUS_TRACE_TS_EN.
- Defined: the timestamp counter is built and rd_ts carries the capture time.
- Undefined: no counter and no timestamp storage; rd_ts is tied to 0; all other behaviour is identical.

Verification
REQ-040 cpu6502 running LDX #$FF; TXS; JSR $5597 from 0x2200, with MODE=1, WIN 0x0100..0x01FF -> exactly two records: {rw=0, addr=0x01FF, data=0x22}, then {rw=0, addr=0x01FE, data=0x05}.
REQ-041 Same program, MODE=2, WIN 0x5597..0x5597 -> one record {rw=1, addr=0x5597, data=0xEA}.
REQ-042 DEPTH=4, six writes with no pops -> full=1, count=4, overflow=1, drops=2; four pops return the first four records in order.
REQ-043 With full=1, a push and rd_en in the same cycle -> count stays 4, the oldest record is popped, the new record is stored.
REQ-044 Reset pulse while count=3 -> count=0, empty=1, overflow=0, rd_valid=0 immediately (asynchronous).
REQ-045 With BUS_TRACE_TS_EN, TS_W=4, captures 20 cycles apart -> rd_ts values differ by 4 (mod 16); without the macro, rd_ts=0.

Source files
------------

// File: rtl/bus_trace.sv
// bus_trace: snoops a CPU bus and records qualified cycles into a trace FIFO.
// Writes are captured on the phi2 rising edge and reads on the phi2 falling edge.
// Capture is filtered by MODE (all, writes only, reads only) and by the address
// window WIN_LO..WIN_HI.
// Optional feature: define BUS_TRACE_TS_EN to build the free-running timestamp
// counter and per-record timestamps; otherwise rd_ts is tied to zero.
module bus_trace #(
   parameter int                ADDR_W = 16,
   parameter int                DATA_W = 8,
   parameter int                DEPTH  = 16,
   parameter int                TS_W   = 16,
   parameter int                MODE   = 0,
   parameter logic [ADDR_W-1:0] WIN_LO = {ADDR_W{1'b0}},
   parameter logic [ADDR_W-1:0] WIN_HI = {ADDR_W{1'b1}}
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          idata,
   input  logic [DATA_W-1:0]          odata,
   input  logic                       rw,
   input  logic                       clk2,
   input  logic                       freeze,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic [TS_W-1:0]            rd_ts,
   output logic                       rd_rw,
   output logic [ADDR_W-1:0]          rd_addr,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic [7:0]                 drops
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // Window test is done as (addr - WIN_LO) <= (WIN_HI - WIN_LO) with one
   // extra bit so an address below WIN_LO lands above the span.
   localparam logic [ADDR_W:0] WIN_SPAN = {1'b0, WIN_HI} - {1'b0, WIN_LO};

   logic                clk2_q_r;
   logic                phi2_rise_s;
   logic                phi2_fall_s;
   logic                cand_s;
   logic                mode_ok_s;
   logic                in_win_s;
   logic [ADDR_W:0]     off_s;
   logic [DATA_W-1:0]   cand_data_s;
   logic                push_s;
   logic                pop_s;
   logic                store_s;
   logic                drop_s;
   logic [AW-1:0]       wr_ptr_r;
   logic [AW-1:0]       rd_ptr_r;

   logic                mem_rw_r   [DEPTH];
   logic [ADDR_W-1:0]   mem_addr_r [DEPTH];
   logic [DATA_W-1:0]   mem_data_r [DEPTH];

`ifdef BUS_TRACE_TS_EN
   logic [TS_W-1:0]     ts_r;
   logic [TS_W-1:0]     mem_ts_r   [DEPTH];
`endif

   assign empty = (count == {CW{1'b0}});
   assign full  = (count == CW'(DEPTH));

   // Decode which cycle types the configured mode lets through.
   always_comb begin
      mode_ok_s = 1'b0;
      case (MODE)
         32'sd0:  mode_ok_s = 1'b1;
         32'sd1:  mode_ok_s = ~rw;
         32'sd2:  mode_ok_s = rw;
         default: mode_ok_s = 1'b0;
      endcase
   end

   // Edge detection, qualification and push/pop arbitration.
   always_comb begin
      phi2_rise_s = clk2 & ~clk2_q_r;
      phi2_fall_s = ~clk2 & clk2_q_r;
      cand_s      = (phi2_rise_s & ~rw) | (phi2_fall_s & rw);
      off_s       = {1'b0, addr} - {1'b0, WIN_LO};
      in_win_s    = (off_s <= WIN_SPAN);
      cand_data_s = rw ? idata : odata;
      push_s      = cand_s & ~freeze & in_win_s & mode_ok_s;
      pop_s       = rd_en & ~empty;
      // A pop frees the slot the push reuses, so a full FIFO still accepts.
      store_s     = push_s & (~full | pop_s);
      drop_s      = push_s & full & ~pop_s;
   end

   // Record storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (store_s) begin
         mem_rw_r[wr_ptr_r]   <= rw;
         mem_addr_r[wr_ptr_r] <= addr;
         mem_data_r[wr_ptr_r] <= cand_data_s;
`ifdef BUS_TRACE_TS_EN
         mem_ts_r[wr_ptr_r]   <= ts_r;
`endif
      end
   end

   // Control state: phase register, pointers, occupancy, overflow and pop output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk2_q_r <= 1'b0;
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count    <= {CW{1'b0}};
         overflow <= 1'b0;
         drops    <= 8'd0;
         rd_valid <= 1'b0;
         rd_rw    <= 1'b0;
         rd_addr  <= {ADDR_W{1'b0}};
         rd_data  <= {DATA_W{1'b0}};
      end else begin
         clk2_q_r <= clk2;
         rd_valid <= pop_s;
         if (store_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
            rd_rw    <= mem_rw_r[rd_ptr_r];
            rd_addr  <= mem_addr_r[rd_ptr_r];
            rd_data  <= mem_data_r[rd_ptr_r];
         end
         case ({store_s, pop_s})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop_s) begin
            overflow <= 1'b1;
            if (drops != 8'hFF) begin
               drops <= drops + 8'd1;
            end
         end
      end
   end

`ifdef BUS_TRACE_TS_EN
   // Free-running timestamp and the timestamp field of the popped record.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_r  <= {TS_W{1'b0}};
         rd_ts <= {TS_W{1'b0}};
      end else begin
         ts_r <= ts_r + TS_W'(1);
         if (pop_s) begin
            rd_ts <= mem_ts_r[rd_ptr_r];
         end
      end
   end
`else
   assign rd_ts = {TS_W{1'b0}};
`endif

endmodule

// File: tb/tb_bus_trace.sv
// tb_bus_trace: directed bench for bus_trace. Three instances share one bus:
// a = capture everything (DEPTH 4), b = writes in 0x0100..0x01FF,
// c = reads of 0x5597 only.
module tb_bus_trace;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  idata = 8'h00;
   logic [7:0]  odata = 8'h00;
   logic        rw = 1'b1;
   logic        clk2 = 1'b0;
   logic        freeze = 1'b0;
   logic        rd_en = 1'b0;

   logic        a_rd_valid, a_rd_rw, a_empty, a_full, a_overflow;
   logic [15:0] a_rd_ts, a_rd_addr;
   logic [7:0]  a_rd_data, a_drops;
   logic [2:0]  a_count;
   logic        b_rd_valid, b_rd_rw, b_empty, b_full, b_overflow;
   logic [15:0] b_rd_ts, b_rd_addr;
   logic [7:0]  b_rd_data, b_drops;
   logic [2:0]  b_count;
   logic        c_rd_valid, c_rd_rw, c_empty, c_full, c_overflow;
   logic [15:0] c_rd_ts, c_rd_addr;
   logic [7:0]  c_rd_data, c_drops;
   logic [2:0]  c_count;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   bus_trace #(.DEPTH(4), .MODE(0)) dut_a (
      .clk(clk), .reset(reset), .addr(addr), .idata(idata), .odata(odata),
      .rw(rw), .clk2(clk2), .freeze(freeze), .rd_en(rd_en),
      .rd_valid(a_rd_valid), .rd_ts(a_rd_ts), .rd_rw(a_rd_rw), .rd_addr(a_rd_addr),
      .rd_data(a_rd_data), .count(a_count), .empty(a_empty), .full(a_full),
      .overflow(a_overflow), .drops(a_drops));

   bus_trace #(.DEPTH(4), .MODE(1), .WIN_LO(16'h0100), .WIN_HI(16'h01FF)) dut_b (
      .clk(clk), .reset(reset), .addr(addr), .idata(idata), .odata(odata),
      .rw(rw), .clk2(clk2), .freeze(freeze), .rd_en(rd_en),
      .rd_valid(b_rd_valid), .rd_ts(b_rd_ts), .rd_rw(b_rd_rw), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .count(b_count), .empty(b_empty), .full(b_full),
      .overflow(b_overflow), .drops(b_drops));

   bus_trace #(.DEPTH(4), .MODE(2), .WIN_LO(16'h5597), .WIN_HI(16'h5597)) dut_c (
      .clk(clk), .reset(reset), .addr(addr), .idata(idata), .odata(odata),
      .rw(rw), .clk2(clk2), .freeze(freeze), .rd_en(rd_en),
      .rd_valid(c_rd_valid), .rd_ts(c_rd_ts), .rd_rw(c_rd_rw), .rd_addr(c_rd_addr),
      .rd_data(c_rd_data), .count(c_count), .empty(c_empty), .full(c_full),
      .overflow(c_overflow), .drops(c_drops));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write bus cycle: captured on the phi2 rise; optional pop on that same edge.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic pop);
      addr = a; odata = d; rw = 1'b0; clk2 = 1'b1; rd_en = pop;
      step();
      rd_en = 1'b0; clk2 = 1'b0;
      step();
   endtask

   // Read bus cycle: captured on the phi2 fall.
   task automatic bus_read(input logic [15:0] a, input logic [7:0] d);
      addr = a; idata = d; rw = 1'b1; clk2 = 1'b1;
      step();
      clk2 = 1'b0;
      step();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   logic [15:0] exp_addr [4] = '{16'h1001, 16'h1002, 16'h1003, 16'h2000};
   logic [7:0]  exp_data [4] = '{8'h11, 8'h12, 8'h13, 8'h77};
   logic [15:0] ts0, ts1;

   initial begin
      // Reset state
      step(); step();
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_empty", 32'(a_empty), 32'd1);
      chk("rst_full", 32'(a_full), 32'd0);
      chk("rst_overflow", 32'(a_overflow), 32'd0);
      chk("rst_valid", 32'(a_rd_valid), 32'd0);
      chk("rst_ts", 32'(a_rd_ts), 32'd0);
      @(negedge clk); reset = 1'b0;
      step();

      // 6502: LDX #$FF; TXS; JSR $5597 from 0x2200
      bus_read(16'h2200, 8'hA2); bus_read(16'h2201, 8'hFF);
      bus_read(16'h2202, 8'h9A); bus_read(16'h2203, 8'h20);
      bus_read(16'h2203, 8'h20); bus_read(16'h2204, 8'h97);
      bus_read(16'h01FF, 8'h00);
      bus_write(16'h01FF, 8'h22, 1'b0); bus_write(16'h01FE, 8'h05, 1'b0);
      bus_read(16'h2205, 8'h55); bus_read(16'h5597, 8'hEA);
      chk("trace_a_count", 32'(a_count), 32'd4);
      chk("trace_a_drops", 32'(a_drops), 32'd7);
      chk("trace_a_ovf", 32'(a_overflow), 32'd1);
      chk("trace_b_count", 32'(b_count), 32'd2);
      chk("trace_c_count", 32'(c_count), 32'd1);

      pop();
      chk("p1_a_valid", 32'(a_rd_valid), 32'd1);
      chk("p1_a_rw", 32'(a_rd_rw), 32'd1);
      chk("p1_a_addr", 32'(a_rd_addr), 32'h2200);
      chk("p1_a_data", 32'(a_rd_data), 32'hA2);
      chk("p1_b_rw", 32'(b_rd_rw), 32'd0);
      chk("p1_b_addr", 32'(b_rd_addr), 32'h01FF);
      chk("p1_b_data", 32'(b_rd_data), 32'h22);
      chk("p1_c_valid", 32'(c_rd_valid), 32'd1);
      chk("p1_c_rw", 32'(c_rd_rw), 32'd1);
      chk("p1_c_addr", 32'(c_rd_addr), 32'h5597);
      chk("p1_c_data", 32'(c_rd_data), 32'hEA);
      pop();
      chk("p2_a_addr", 32'(a_rd_addr), 32'h2201);
      chk("p2_b_addr", 32'(b_rd_addr), 32'h01FE);
      chk("p2_b_data", 32'(b_rd_data), 32'h05);
      chk("p2_c_valid", 32'(c_rd_valid), 32'd0);
      chk("p2_c_hold", 32'(c_rd_data), 32'hEA);
      pop();
      chk("p3_a_valid", 32'(a_rd_valid), 32'd1);
      chk("p3_a_addr", 32'(a_rd_addr), 32'h2202);
      chk("p3_b_valid", 32'(b_rd_valid), 32'd0);
      chk("p3_b_empty", 32'(b_empty), 32'd1);

      // Asynchronous reset between clock edges
      reset = 1'b1;
      #2;
      chk("arst_valid", 32'(a_rd_valid), 32'd0);
      chk("arst_count", 32'(a_count), 32'd0);
      chk("arst_empty", 32'(a_empty), 32'd1);
      chk("arst_ovf", 32'(a_overflow), 32'd0);
      chk("arst_drops", 32'(a_drops), 32'd0);
      chk("arst_addr", 32'(a_rd_addr), 32'd0);
      @(negedge clk); reset = 1'b0;
      step();

      // Six writes into a 4-deep FIFO
      for (int i = 0; i < 6; i++) begin
         bus_write(16'(32'h1000 + i), 8'(32'h10 + i), 1'b0);
      end
      chk("fill_count", 32'(a_count), 32'd4);
      chk("fill_full", 32'(a_full), 32'd1);
      chk("fill_empty", 32'(a_empty), 32'd0);
      chk("fill_ovf", 32'(a_overflow), 32'd1);
      chk("fill_drops", 32'(a_drops), 32'd2);
      chk("fill_b_window", 32'(b_count), 32'd0);

      // Push and pop on the same edge while full
      bus_write(16'h2000, 8'h77, 1'b1);
      chk("pp_count", 32'(a_count), 32'd4);
      chk("pp_drops", 32'(a_drops), 32'd2);
      chk("pp_addr", 32'(a_rd_addr), 32'h1000);
      chk("pp_data", 32'(a_rd_data), 32'h10);
      for (int i = 0; i < 4; i++) begin
         pop();
         chk("drain_valid", 32'(a_rd_valid), 32'd1);
         chk("drain_addr", 32'(a_rd_addr), 32'(exp_addr[i]));
         chk("drain_data", 32'(a_rd_data), 32'(exp_data[i]));
      end
      chk("drain_empty", 32'(a_empty), 32'd1);
      pop();
      chk("empty_pop_valid", 32'(a_rd_valid), 32'd0);
      chk("empty_pop_hold", 32'(a_rd_addr), 32'h2000);

      // Freeze rising with a candidate blocks it; popping still works
      freeze = 1'b1;
      bus_write(16'h3000, 8'hAA, 1'b0);
      chk("frz_count", 32'(a_count), 32'd0);
      freeze = 1'b0;
      bus_write(16'h3001, 8'hBB, 1'b0);
      chk("unfrz_count", 32'(a_count), 32'd1);
      freeze = 1'b1;
      pop();
      chk("frz_pop_valid", 32'(a_rd_valid), 32'd1);
      chk("frz_pop_addr", 32'(a_rd_addr), 32'h3001);
      freeze = 1'b0;

      // Timestamps of captures 20 cycles apart
      bus_write(16'h4000, 8'h01, 1'b0);
      for (int i = 0; i < 18; i++) step();
      bus_write(16'h4001, 8'h02, 1'b0);
      pop(); ts0 = a_rd_ts;
      pop(); ts1 = a_rd_ts;
      chk("ts_addr", 32'(a_rd_addr), 32'h4001);
`ifdef BUS_TRACE_TS_EN
      chk("ts_delta", 32'(16'(ts1 - ts0)), 32'd20);
`else
      chk("ts0_zero", 32'(ts0), 32'd0);
      chk("ts1_zero", 32'(ts1), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
